// File: rtl/conv2_pkg.sv
// Shared types and default geometry for the conv2 window path.
package conv2_pkg;

  localparam int unsigned IMG_W_DEF  = 14;
  localparam int unsigned IMG_H_DEF  = 14;
  localparam int unsigned DATA_W_DEF = 32;

  // IEEE-754 single, carried as opaque bits.
  typedef logic [31:0] fp32_t;

  // 3x3 window, row-major: [0] = top-left, [4] = centre, [8] = newest pixel.
  typedef fp32_t [0:8] window_t;

endpackage

// File: rtl/conv2_line_fifo.sv
// Valid-gated delay line; tap 0 is din itself, taps 1 and 2 are the two most
// recent stored words, dout is din delayed by DEPTH accepted beats.
module conv2_line_fifo
  import conv2_pkg::*;
#(
  parameter int unsigned DEPTH  = IMG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] sr_q [0:DEPTH-1];

  // Shift one word per accepted beat; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sr_q[i] <= '0;
      end
    end else if (shift_en) begin
      sr_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign tap1 = sr_q[0];
  assign tap2 = sr_q[1];
  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv2_window_buf.sv
// Streaming 3x3 window generator: raster pixels in, one registered valid-only
// window per pulse out, frame_done on the last window of each plane.
module conv2_window_buf
  import conv2_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out [0:8],
  output logic              valid_out,
  output logic              frame_done
);

  localparam int unsigned COL_W   = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int unsigned ROW_W   = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam int unsigned N_LINES = 3;

  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  col_nxt_c;
  logic [ROW_W-1:0]  row_q;
  logic [ROW_W-1:0]  row_nxt_c;
  logic              emit_c;
  logic              last_c;

  // line_in[g] is the stream delayed by g rows; line_in[N_LINES] is the spare tail.
  logic [DATA_W-1:0] line_in [0:N_LINES];
  logic [DATA_W-1:0] tap1    [0:N_LINES-1];
  logic [DATA_W-1:0] tap2    [0:N_LINES-1];
  logic [DATA_W-1:0] win_c   [0:8];

  assign line_in[0] = data_in;

  // Three chained lines; the oldest row only needs its first two stored words.
  for (genvar g = 0; g < int'(N_LINES); g++) begin : g_line
    localparam int unsigned LINE_DEPTH = (g == int'(N_LINES) - 1) ? 2 : IMG_W;
    conv2_line_fifo #(
      .DEPTH  (LINE_DEPTH),
      .DATA_W (DATA_W)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (valid_in),
      .din      (line_in[g]),
      .tap1     (tap1[g]),
      .tap2     (tap2[g]),
      .dout     (line_in[g+1])
    );
  end

  // Window row j comes from line 2-j: oldest column first.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_c[k] = '0;
    end
    for (int j = 0; j < 3; j++) begin
      win_c[3*j]     = tap2[2-j];
      win_c[3*j + 1] = tap1[2-j];
      win_c[3*j + 2] = line_in[2-j];
    end
  end

  // Position tracking and emission decision for the incoming beat.
  always_comb begin
    col_nxt_c = col_q;
    row_nxt_c = row_q;
    emit_c    = 1'b0;
    last_c    = 1'b0;
    if (valid_in) begin
      emit_c = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      last_c = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_nxt_c = '0;
        if (row_q == ROW_W'(IMG_H - 1)) begin
          row_nxt_c = '0;
        end else begin
          row_nxt_c = row_q + ROW_W'(1);
        end
      end else begin
        col_nxt_c = col_q + COL_W'(1);
      end
    end
  end

  // Counters and output registers; data_out holds between emissions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        data_out[k] <= '0;
      end
    end else begin
      col_q      <= col_nxt_c;
      row_q      <= row_nxt_c;
      valid_out  <= emit_c;
      frame_done <= emit_c && last_c;
      if (emit_c) begin
        for (int k = 0; k < 9; k++) begin
          data_out[k] <= win_c[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_buf.sv
// Bench for conv2_window_buf: image-array reference model, per-cycle compare,
// plus literal window checks that pin the model.
module tb_conv2_window_buf;
  import conv2_pkg::*;

  localparam int W = 14;
  localparam int H = 14;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [31:0] data_out [0:8];
  logic        valid_out;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  conv2_window_buf #(.IMG_W(W), .IMG_H(H), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the current plane as a 2D image; windows read by (r, c).
  logic [31:0] img [0:H-1][0:W-1];
  int          mr, mc;
  window_t     exp_win;
  logic        exp_v, exp_f;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr      <= 0;
      mc      <= 0;
      exp_v   <= 1'b0;
      exp_f   <= 1'b0;
      exp_win <= '0;
    end else begin
      exp_v <= 1'b0;
      exp_f <= 1'b0;
      if (valid_in) begin
        img[mr][mc] <= data_in;
        if (mr >= 2 && mc >= 2) begin
          for (int k = 0; k < 9; k++)
            exp_win[k] <= (k == 8) ? data_in : img[mr - 2 + k / 3][mc - 2 + k % 3];
          exp_v <= 1'b1;
          exp_f <= (mr == H - 1) && (mc == W - 1);
        end
        if (mc == W - 1) begin
          mc <= 0;
          mr <= (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc <= mc + 1;
        end
      end
    end
  end

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_win(input string nm, input window_t got, input window_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic window_t pack_out();
    window_t w;
    for (int k = 0; k < 9; k++) w[k] = data_out[k];
    return w;
  endfunction

  // Windows seen in the current scenario and frame_done pulse count.
  window_t win_q[$];
  window_t s1_q[$];
  int      frames;

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    window_t got;
    got = pack_out();
    chk_int("valid_out", int'(valid_out), int'(exp_v));
    chk_int("frame_done", int'(frame_done), int'(exp_f));
    chk_win("data_out", got, exp_win);
    if (valid_out) begin
      win_q.push_back(got);
      if (frame_done) frames++;
    end
  end

  task automatic send(input int first, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      valid_in = 1'b1;
      data_in  = (mode == 2) ? $urandom : 32'(first + i);
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        @(posedge clk); #2;
        valid_in = 1'b0;
      end
    end
    @(posedge clk); #2;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    win_q.delete();
    frames = 0;
  endtask

  task automatic chk_zero_outputs(input string nm);
    @(negedge clk);
    chk_int({nm, "_valid"}, int'(valid_out), 0);
    chk_int({nm, "_frame"}, int'(frame_done), 0);
    chk_win({nm, "_data"}, pack_out(), '0);
  endtask

  task automatic chk_same_as_s1(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < win_q.size() && i < s1_q.size(); i++)
      if (win_q[i] !== s1_q[i]) bad++;
    chk_int(nm, bad, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    frames   = 0;
    chk_zero_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Continuous plane with data = pixel index.
    clear_log();
    send(0, 196, 0);
    idle(3);
    chk_int("s1_count", win_q.size(), 144);
    chk_int("s1_frames", frames, 1);
    if (win_q.size() == 144) begin
      chk_win("s1_first", win_q[0],
              {32'd0, 32'd1, 32'd2, 32'd14, 32'd15, 32'd16, 32'd28, 32'd29, 32'd30});
      chk_int("s1_before_row_edge", int'(win_q[11][8]), 41);
      chk_win("s1_row_edge", win_q[12],
              {32'd14, 32'd15, 32'd16, 32'd28, 32'd29, 32'd30, 32'd42, 32'd43, 32'd44});
      chk_win("s1_last", win_q[143],
              {32'd165, 32'd166, 32'd167, 32'd179, 32'd180, 32'd181, 32'd193, 32'd194, 32'd195});
    end
    s1_q = win_q;

    // Same plane, valid every other cycle.
    clear_log();
    send(0, 196, 1);
    idle(3);
    chk_int("alt_count", win_q.size(), 144);
    chk_int("alt_frames", frames, 1);
    chk_same_as_s1("alt_sequence");

    // Two back-to-back planes.
    clear_log();
    send(0, 392, 0);
    idle(3);
    chk_int("b2b_count", win_q.size(), 288);
    chk_int("b2b_frames", frames, 2);
    if (win_q.size() == 288) begin
      chk_win("b2b_p1_last", win_q[143],
              {32'd165, 32'd166, 32'd167, 32'd179, 32'd180, 32'd181, 32'd193, 32'd194, 32'd195});
      chk_win("b2b_p2_first", win_q[144],
              {32'd196, 32'd197, 32'd198, 32'd210, 32'd211, 32'd212, 32'd224, 32'd225, 32'd226});
    end

    // Reset mid-plane, then a fresh plane.
    send(1000, 50, 0);
    rst_n = 1'b0;
    chk_zero_outputs("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_log();
    send(0, 196, 0);
    idle(3);
    chk_int("rst_count", win_q.size(), 144);
    chk_int("rst_frames", frames, 1);
    if (win_q.size() == 144) begin
      chk_win("rst_first", win_q[0],
              {32'd0, 32'd1, 32'd2, 32'd14, 32'd15, 32'd16, 32'd28, 32'd29, 32'd30});
      chk_win("rst_last", win_q[143],
              {32'd165, 32'd166, 32'd167, 32'd179, 32'd180, 32'd181, 32'd193, 32'd194, 32'd195});
    end
    chk_same_as_s1("rst_sequence");

    // Random data with random gaps over two planes.
    clear_log();
    send(0, 392, 2);
    idle(3);
    chk_int("rand_count", win_q.size(), 288);
    chk_int("rand_frames", frames, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2_window_buf.md
# conv2_window_buf

Streaming 3x3 window generator that feeds the conv2 filter stage. It accepts one fp32 feature-map pixel per valid beat in raster order, one channel plane at a time. It buffers two full rows plus three pixels and presents each complete 3x3 neighbourhood on a nine-word bus, with a one-cycle valid pulse. It applies no padding: valid convolution only, giving an (IMG_W-2) x (IMG_H-2) output plane per input plane.

## Interface
Parameters:
- IMG_W, default 14: pixels per row; minimum 3.
- IMG_H, default 14: rows per plane; minimum 3.
- DATA_W, default 32: word width (IEEE-754 single, treated as opaque bits).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- valid_in, in, 1: data_in carries a pixel this cycle.
- data_in, in, DATA_W: pixel, raster order (row-major, column fastest).
- data_out[0:8], out, 9 x DATA_W: window, row-major; [0] = (r-2, c-2), [4] = (r-1, c-1), [8] = (r, c), where (r, c) is the pixel that completed the window.
- valid_out, out, 1: one-cycle pulse; data_out holds a new window.
- frame_done, out, 1: one-cycle pulse, coincident with valid_out for the last window of a plane.

## Operation
- Pixel storage: a delay line of 2*IMG_W+3 words that shifts only on valid_in. Taps at offsets 0, 1, 2, IMG_W, IMG_W+1, IMG_W+2, 2*IMG_W, 2*IMG_W+1 and 2*IMG_W+2 form the window.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the incoming pixel. They advance only on valid_in.
  - col wraps to 0 after IMG_W-1, and row then increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
  - The next beat starts a new plane with no idle cycles required.
- Window emission: on a valid_in beat with row >= 2 and col >= 2, register the window into data_out and set valid_out for one cycle.
- Invalid positions: beats with col < 2 or row < 2 produce no valid_out. Windows never straddle a row wrap or a plane boundary.
- Plane end: on the beat at (IMG_H-1, IMG_W-1), frame_done pulses alongside valid_out.
- Output hold: data_out holds its value between pulses. It does not change on non-emitting cycles.
- No backpressure: the downstream filter must accept every pulse. valid_in gaps of any length are legal and do not disturb state.
- Stale data: stale delay-line contents from a previous plane are never emitted, because the row >= 2 gating guarantees the line is refilled first.

## Timing
- Latency: valid_out asserts in the cycle after the completing valid_in beat (one register stage).
- Throughput: one window per clock when valid_in is continuous.
- Reset values: data_out all zero, valid_out 0, frame_done 0, col 0, row 0. The delay line is also cleared to zero.
- Reset mid-plane: all state is discarded and the next valid_in beat is treated as pixel (0, 0) of a new plane.
- Simultaneous plane wrap and new pixel: impossible by construction, since each beat is exactly one pixel.
- Windows per plane: (IMG_W-2)*(IMG_H-2), 144 at the default parameters.

## Structure
- Shared package conv2_pkg holds:
  - IMG_W, IMG_H and DATA_W defaults;
  - typedef fp32_t (logic [31:0]);
  - typedef window_t (fp32_t [0:8]).
- Sub-module conv2_line_fifo: an IMG_W-deep, valid-gated delay line with taps at 0, 1 and 2. Instantiate it three times, chained, to produce the window rows. The top level holds the counters, emission logic and output registers.

## Test plan
All scenarios use default parameters and data_in = pixel index (integer bit patterns), so windows are checkable by value.
- Continuous plane of 196 pixels:
  - first valid_out follows pixel 30 with data_out = {0,1,2,14,15,16,28,29,30};
  - exactly 144 pulses;
  - last window is {165,166,167,179,180,181,193,194,195}, with frame_done high;
  - frame_done is low on all other cycles.
- Same plane with valid_in high every other cycle: an identical sequence of 144 windows, with valid_out only in the cycle after an emitting beat and data_out stable in between.
- Two back-to-back planes (indices 0..391):
  - no window emitted for the first 30 beats of plane two;
  - plane two's first window is {196,197,198,210,211,212,224,225,226}.
- Row-edge check: beats at col 0 and col 1 (e.g. pixels 42 and 43) produce no valid_out; pixel 44 yields {14,15,16,28,29,30,42,43,44}.
- Reset mid-plane:
  - after 50 pixels, pulse rst_n low; all outputs read zero during reset;
  - a fresh plane then behaves exactly as in the first scenario, with no leftover indices in any window.
